// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module : multicycle_ctrl_pkg
// Brief  : Shared opcodes, ALU command codes, state encoding and decode types
//          for the WISC-15 multi-cycle controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    localparam logic [3:0] c_OP_ADD    = 4'b0000;
    localparam logic [3:0] c_OP_PADDSB = 4'b0001;
    localparam logic [3:0] c_OP_SUB    = 4'b0010;
    localparam logic [3:0] c_OP_NAND   = 4'b0011;
    localparam logic [3:0] c_OP_XOR    = 4'b0100;
    localparam logic [3:0] c_OP_SLL    = 4'b0101;
    localparam logic [3:0] c_OP_SRL    = 4'b0110;
    localparam logic [3:0] c_OP_SRA    = 4'b0111;
    localparam logic [3:0] c_OP_LW     = 4'b1000;
    localparam logic [3:0] c_OP_SW     = 4'b1001;
    localparam logic [3:0] c_OP_LHB    = 4'b1010;
    localparam logic [3:0] c_OP_LLB    = 4'b1011;
    localparam logic [3:0] c_OP_B      = 4'b1100;
    localparam logic [3:0] c_OP_CALL   = 4'b1101;
    localparam logic [3:0] c_OP_RET    = 4'b1110;
    localparam logic [3:0] c_OP_HLT    = 4'b1111;

    localparam logic [3:0] c_ALU_ADD    = 4'b0000;
    localparam logic [3:0] c_ALU_SUB    = 4'b0001;
    localparam logic [3:0] c_ALU_PADDSB = 4'b0010;
    localparam logic [3:0] c_ALU_XOR    = 4'b0100;
    localparam logic [3:0] c_ALU_NAND   = 4'b1000;
    localparam logic [3:0] c_ALU_SLL    = 4'b1100;
    localparam logic [3:0] c_ALU_SRL    = 4'b1110;
    localparam logic [3:0] c_ALU_SRA    = 4'b1111;

    localparam logic [2:0] c_ST_BOOT   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALTED = 3'd6;
    localparam logic [2:0] c_ST_FAULT  = 3'd7;

    // Instruction class selects the path through the sequencer.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_CALL,
        CLS_RET,
        CLS_HLT
    } instr_class_e;

    typedef struct packed {
        logic [3:0]   alu_cmd;
        logic         alu_src;
        logic         mem_to_reg;
        logic         set_z;
        logic         set_v;
        instr_class_e cls;
    } decode_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Memory handshake, datapath control and status bundle of the
//          WISC-15 controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int ALU_CMD_W = 4,
    parameter int RET_W     = 16
) ();
    logic                 imem_rdy;
    logic [3:0]           opcode;
    logic                 dmem_rdy;
    logic                 imem_req;
    logic                 ir_wrt;
    logic                 pc_wrt;
    logic                 dmem_req;
    logic [ALU_CMD_W-1:0] alu_cmd;
    logic                 alu_src;
    logic                 mem_to_reg;
    logic                 reg_wrt;
    logic                 mem_wrt;
    logic                 branch;
    logic                 call;
    logic                 ret;
    logic                 set_zero;
    logic                 set_over;
    logic                 halt;
    logic                 fault;
    logic [2:0]           state;
    logic [RET_W-1:0]     retired;

    modport master (
        input  imem_rdy, opcode, dmem_rdy,
        output imem_req, ir_wrt, pc_wrt, dmem_req, alu_cmd, alu_src,
               mem_to_reg, reg_wrt, mem_wrt, branch, call, ret,
               set_zero, set_over, halt, fault, state, retired
    );

    modport slave (
        output imem_rdy, opcode, dmem_rdy,
        input  imem_req, ir_wrt, pc_wrt, dmem_req, alu_cmd, alu_src,
               mem_to_reg, reg_wrt, mem_wrt, branch, call, ret,
               set_zero, set_over, halt, fault, state, retired
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ============================================================================
// Module : ctrl_decode
// Brief  : Combinational opcode decoder: ALU command, mux selects, flag mask
//          and instruction class.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output decode_t    o_dec
);

    always_comb begin
        o_dec = '{alu_cmd: c_ALU_ADD, alu_src: 1'b0, mem_to_reg: 1'b0,
                  set_z: 1'b0, set_v: 1'b0, cls: CLS_ALU};
        case (i_opcode)
            c_OP_ADD:    begin o_dec.set_z = 1'b1; o_dec.set_v = 1'b1; end
            c_OP_PADDSB: o_dec.alu_cmd = c_ALU_PADDSB;
            c_OP_SUB:    begin
                o_dec.alu_cmd = c_ALU_SUB;
                o_dec.set_z   = 1'b1;
                o_dec.set_v   = 1'b1;
            end
            c_OP_NAND:   begin o_dec.alu_cmd = c_ALU_NAND; o_dec.set_z = 1'b1; end
            c_OP_XOR:    begin o_dec.alu_cmd = c_ALU_XOR;  o_dec.set_z = 1'b1; end
            c_OP_SLL:    begin
                o_dec.alu_cmd = c_ALU_SLL; o_dec.set_z = 1'b1; o_dec.alu_src = 1'b1;
            end
            c_OP_SRL:    begin
                o_dec.alu_cmd = c_ALU_SRL; o_dec.set_z = 1'b1; o_dec.alu_src = 1'b1;
            end
            c_OP_SRA:    begin
                o_dec.alu_cmd = c_ALU_SRA; o_dec.set_z = 1'b1; o_dec.alu_src = 1'b1;
            end
            c_OP_LW:     begin
                o_dec.alu_src = 1'b1; o_dec.mem_to_reg = 1'b1; o_dec.cls = CLS_LW;
            end
            c_OP_SW:     begin o_dec.alu_src = 1'b1; o_dec.cls = CLS_SW; end
            // LHB/LLB keep the defaults: plain register write-back, no flags.
            c_OP_B:      o_dec.cls = CLS_BR;
            c_OP_CALL:   o_dec.cls = CLS_CALL;
            c_OP_RET:    o_dec.cls = CLS_RET;
            c_OP_HLT:    o_dec.cls = CLS_HLT;
            default:     ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : WISC-15 multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with
//          memory wait timeout and retired-instruction counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CMD_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.master     bus
);

    localparam int c_WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_TIMEOUT = c_WCNT_W'(MEM_TIMEOUT);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [3:0]          r_ir;
    logic [c_WCNT_W-1:0] r_wait;
    logic [RET_W-1:0]    r_retired;
    decode_t             w_dec;
    logic                w_fetch_done;
    logic                w_mem_wait;
    logic                w_timeout;
    logic                w_retire;
    logic                w_in_instr;
    logic                w_exec;

    ctrl_decode u_decode (
        .i_opcode (r_ir),
        .o_dec    (w_dec)
    );

    assign w_fetch_done = (r_state == c_ST_FETCH) & bus.imem_rdy;
    assign w_mem_wait   = ((r_state == c_ST_FETCH) & ~bus.imem_rdy) |
                          ((r_state == c_ST_MEM)   & ~bus.dmem_rdy);
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_mem_wait && (r_wait == c_TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_BOOT:   w_next = c_ST_FETCH;
            c_ST_FETCH:  begin
                if (bus.imem_rdy)   w_next = c_ST_DECODE;
                else if (w_timeout) w_next = c_ST_FAULT;
            end
            c_ST_DECODE: w_next = (w_dec.cls == CLS_HLT) ? c_ST_HALTED : c_ST_EXEC;
            c_ST_EXEC:   begin
                if (w_dec.cls == CLS_LW || w_dec.cls == CLS_SW)
                    w_next = c_ST_MEM;
                else if (w_dec.cls == CLS_BR || w_dec.cls == CLS_RET)
                    w_next = c_ST_FETCH;
                else
                    w_next = c_ST_WB;
            end
            c_ST_MEM:    begin
                if (bus.dmem_rdy)   w_next = (w_dec.cls == CLS_LW) ? c_ST_WB : c_ST_FETCH;
                else if (w_timeout) w_next = c_ST_FAULT;
            end
            c_ST_WB:     w_next = c_ST_FETCH;
            c_ST_HALTED: w_next = c_ST_HALTED;
            c_ST_FAULT:  w_next = c_ST_FAULT;
            default:     w_next = c_ST_BOOT;
        endcase
    end

    // An instruction retires when it hands control back to FETCH, or when HLT parks the core.
    assign w_retire = ((w_next == c_ST_FETCH) &&
                       (r_state == c_ST_EXEC || r_state == c_ST_MEM || r_state == c_ST_WB)) ||
                      ((w_next == c_ST_HALTED) && (r_state == c_ST_DECODE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_BOOT;
            r_ir      <= 4'b0000;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_fetch_done)
                r_ir <= bus.opcode;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_mem_wait && MEM_TIMEOUT != 0)
                r_wait <= r_wait + c_WCNT_W'(1);
            if (w_retire)
                r_retired <= r_retired + RET_W'(1);
        end
    end

    assign w_in_instr = (r_state == c_ST_EXEC) | (r_state == c_ST_MEM) | (r_state == c_ST_WB);
    assign w_exec     = (r_state == c_ST_EXEC);

    assign bus.imem_req   = (r_state == c_ST_FETCH);
    assign bus.ir_wrt     = w_fetch_done;
    assign bus.pc_wrt     = w_fetch_done |
                            (w_exec & (w_dec.cls == CLS_BR || w_dec.cls == CLS_CALL ||
                                       w_dec.cls == CLS_RET));
    assign bus.dmem_req   = (r_state == c_ST_MEM);
    assign bus.mem_wrt    = (r_state == c_ST_MEM) & (w_dec.cls == CLS_SW);
    assign bus.alu_cmd    = w_in_instr ? ALU_CMD_W'(w_dec.alu_cmd) : '0;
    assign bus.alu_src    = w_in_instr & w_dec.alu_src;
    assign bus.mem_to_reg = w_in_instr & w_dec.mem_to_reg;
    assign bus.reg_wrt    = (r_state == c_ST_WB);
    assign bus.branch     = w_exec & (w_dec.cls == CLS_BR);
    assign bus.call       = w_exec & (w_dec.cls == CLS_CALL);
    assign bus.ret        = w_exec & (w_dec.cls == CLS_RET);
    assign bus.set_zero   = w_exec & w_dec.set_z;
    assign bus.set_over   = w_exec & w_dec.set_v;
    assign bus.halt       = (r_state == c_ST_HALTED);
    assign bus.fault      = (r_state == c_ST_FAULT);
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Self-checking bench: directed scenarios plus randomized opcode and
//          memory-ready stimulus against a per-instruction phase-plan model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.ALU_CMD_W(4), .RET_W(16)) bus ();

    multicycle_ctrl #(.ALU_CMD_W(4), .MEM_TIMEOUT(TO), .RET_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: current phase, latched opcode, remaining phases of the instruction.
    logic [2:0]  m_ph   = c_ST_BOOT;
    logic [3:0]  m_op   = 4'h0;
    int          m_wait = 0;
    logic [15:0] m_ret  = 16'h0;
    logic [2:0]  m_plan[$];

    logic [3:0]  t_alu[16] = '{4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b1100,
                               4'b1110, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [15:0] t_zmask = 16'h00FD;
    logic [15:0] t_vmask = 16'h0005;
    logic [15:0] t_src   = 16'h03E0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph   = c_ST_BOOT;
        m_op   = 4'h0;
        m_wait = 0;
        m_ret  = 16'h0;
        m_plan.delete();
    endtask

    task automatic build_plan(input logic [3:0] op);
        m_plan.delete();
        m_plan.push_back(c_ST_DECODE);
        if (op == 4'hF) begin
            m_plan.push_back(c_ST_HALTED);
        end else begin
            m_plan.push_back(c_ST_EXEC);
            case (op)
                4'h8:       begin m_plan.push_back(c_ST_MEM); m_plan.push_back(c_ST_WB); end
                4'h9:       m_plan.push_back(c_ST_MEM);
                4'hC, 4'hE: ;
                default:    m_plan.push_back(c_ST_WB);
            endcase
        end
    endtask

    task automatic finish_phase();
        if (m_plan.size() == 0) begin
            m_ph = c_ST_FETCH;
            m_ret++;
        end else begin
            m_ph = m_plan.pop_front();
            if (m_ph == c_ST_HALTED) m_ret++;
        end
    endtask

    task automatic model_step();
        logic [2:0] prev;
        if (rst) begin
            model_reset();
            return;
        end
        prev = m_ph;
        case (m_ph)
            c_ST_BOOT:  m_ph = c_ST_FETCH;
            c_ST_FETCH: begin
                if (bus.imem_rdy) begin
                    m_op = bus.opcode;
                    build_plan(m_op);
                    m_ph = m_plan.pop_front();
                end else if (TO != 0 && m_wait == TO) m_ph = c_ST_FAULT;
                else m_wait++;
            end
            c_ST_MEM: begin
                if (bus.dmem_rdy) finish_phase();
                else if (TO != 0 && m_wait == TO) m_ph = c_ST_FAULT;
                else m_wait++;
            end
            c_ST_DECODE, c_ST_EXEC, c_ST_WB: finish_phase();
            default: ;
        endcase
        if (m_ph != prev) m_wait = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic ex, ins, fe;
        ex  = (m_ph == c_ST_EXEC);
        fe  = (m_ph == c_ST_FETCH);
        ins = ex || m_ph == c_ST_MEM || m_ph == c_ST_WB;
        chk("state",      bus.state,      m_ph);
        chk("retired",    bus.retired,    m_ret);
        chk("imem_req",   bus.imem_req,   fe);
        chk("ir_wrt",     bus.ir_wrt,     fe && bus.imem_rdy);
        chk("pc_wrt",     bus.pc_wrt,     (fe && bus.imem_rdy) ||
                                          (ex && (m_op == 4'hC || m_op == 4'hD || m_op == 4'hE)));
        chk("dmem_req",   bus.dmem_req,   m_ph == c_ST_MEM);
        chk("mem_wrt",    bus.mem_wrt,    m_ph == c_ST_MEM && m_op == 4'h9);
        chk("alu_cmd",    bus.alu_cmd,    ins ? t_alu[m_op] : 4'h0);
        chk("alu_src",    bus.alu_src,    ins && t_src[m_op]);
        chk("mem_to_reg", bus.mem_to_reg, ins && m_op == 4'h8);
        chk("reg_wrt",    bus.reg_wrt,    m_ph == c_ST_WB);
        chk("branch",     bus.branch,     ex && m_op == 4'hC);
        chk("call",       bus.call,       ex && m_op == 4'hD);
        chk("ret",        bus.ret,        ex && m_op == 4'hE);
        chk("set_zero",   bus.set_zero,   ex && t_zmask[m_op]);
        chk("set_over",   bus.set_over,   ex && t_vmask[m_op]);
        chk("halt",       bus.halt,       m_ph == c_ST_HALTED);
        chk("fault",      bus.fault,      m_ph == c_ST_FAULT);
    end

    initial begin
        int cnt, regseen, stall, stuck;
        rst = 1'b1;
        bus.imem_rdy = 1'b0;
        bus.dmem_rdy = 1'b0;
        bus.opcode   = 4'h0;
        model_reset();
        tick(); tick();
        chk("rst_state",   bus.state, c_ST_BOOT);
        chk("rst_retired", bus.retired, 0);
        chk("rst_outs",    {bus.imem_req, bus.dmem_req, bus.reg_wrt, bus.halt, bus.fault}, 0);

        // ADD with zero wait states
        rst = 1'b0; bus.imem_rdy = 1'b1; bus.dmem_rdy = 1'b1; bus.opcode = 4'h0;
        chk("add_boot", bus.state, c_ST_BOOT);
        tick(); chk("add_fetch", bus.state, c_ST_FETCH); chk("add_ir_wrt", bus.ir_wrt, 1);
        tick(); chk("add_decode", bus.state, c_ST_DECODE);
        tick(); chk("add_exec", bus.state, c_ST_EXEC);
        chk("add_flags", {bus.set_zero, bus.set_over}, 2'b11);
        chk("add_no_wb_in_exec", bus.reg_wrt, 0);
        tick(); chk("add_wb", bus.state, c_ST_WB); chk("add_reg_wrt", bus.reg_wrt, 1);
        bus.opcode = 4'h9; bus.dmem_rdy = 1'b0;
        tick(); chk("add_refetch", bus.state, c_ST_FETCH); chk("add_retired", bus.retired, 1);

        // SW with three dmem wait cycles
        tick(); tick(); tick();
        chk("sw_mem", bus.state, c_ST_MEM);
        cnt = 0; regseen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.dmem_req && bus.mem_wrt) cnt++;
            if (bus.reg_wrt) regseen = 1;
            if (i == 3) bus.dmem_rdy = 1'b1;
            tick();
        end
        chk("sw_mem_cycles", cnt, 4);
        chk("sw_no_reg_wrt", regseen, 0);
        chk("sw_to_fetch", bus.state, c_ST_FETCH);
        chk("sw_retired", bus.retired, 2);

        // LW
        bus.opcode = 4'h8;
        tick(); tick();
        chk("lw_exec_src", {bus.alu_src, bus.alu_cmd}, 5'b1_0000);
        tick();
        chk("lw_mem_src", bus.alu_src, 1);
        tick();
        chk("lw_wb", {bus.reg_wrt, bus.mem_to_reg, bus.alu_src}, 3'b111);
        bus.imem_rdy = 1'b0;
        tick(); chk("lw_retired", bus.retired, 3);

        // Fetch timeout boundary: ready on the 16th wait cycle still advances
        repeat (15) tick();
        chk("to_fetch16", bus.state, c_ST_FETCH);
        bus.imem_rdy = 1'b1; bus.opcode = 4'hC;
        tick(); chk("to_late_rdy_decode", bus.state, c_ST_DECODE);
        tick(); chk("b_exec", {bus.branch, bus.pc_wrt}, 2'b11);
        bus.imem_rdy = 1'b0;
        tick(); chk("b_retired", bus.retired, 4);
        repeat (15) tick();
        chk("to_still_fetch", bus.state, c_ST_FETCH);
        tick();
        chk("to_fault_state", bus.state, c_ST_FAULT);
        chk("to_fault", {bus.fault, bus.imem_req}, 2'b10);
        bus.imem_rdy = 1'b1;
        repeat (3) tick();
        chk("fault_sticky", bus.fault, 1);
        rst = 1'b1; model_reset();
        tick();
        chk("fault_cleared", {bus.fault, bus.state}, {1'b0, c_ST_BOOT});

        // HLT
        rst = 1'b0; bus.opcode = 4'hF;
        tick(); tick(); tick();
        chk("hlt_state", bus.state, c_ST_HALTED);
        chk("hlt_retired", bus.retired, 1);
        repeat (4) tick();
        chk("hlt_sticky", {bus.halt, bus.imem_req, bus.retired}, {1'b1, 1'b0, 16'd1});
        rst = 1'b1; model_reset();
        #1;
        chk("hlt_rst", {bus.halt, bus.state}, {1'b0, c_ST_BOOT});
        tick();

        // Asynchronous reset in the middle of an SW memory access
        rst = 1'b0; bus.opcode = 4'h0; bus.dmem_rdy = 1'b0;
        tick(); tick();
        bus.opcode = 4'h9;
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("abort_in_mem", {bus.mem_wrt, bus.dmem_req, bus.retired}, {2'b11, 16'd1});
        #2;
        rst = 1'b1; model_reset();
        #1;
        chk("abort_outs", {bus.mem_wrt, bus.dmem_req}, 2'b00);
        chk("abort_retired", bus.retired, 0);
        chk("abort_state", bus.state, c_ST_BOOT);
        tick();
        rst = 1'b0;

        // Randomized traffic
        stall = 0; stuck = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stall > 0) begin
                bus.imem_rdy = 1'b0; bus.dmem_rdy = 1'b0; stall--;
            end else begin
                bus.imem_rdy = ($urandom_range(99) < 70);
                bus.dmem_rdy = ($urandom_range(99) < 60);
                if ($urandom_range(199) == 0) stall = $urandom_range(17, 13);
            end
            bus.opcode = ($urandom_range(63) == 0) ? 4'hF : 4'($urandom_range(14));
            if (m_ph == c_ST_HALTED || m_ph == c_ST_FAULT) stuck++;
            else stuck = 0;
            if (stuck > 4 || $urandom_range(999) == 0) begin
                rst = 1'b1; model_reset(); stuck = 0;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
